// File: rtl/multicycle_add.sv
// Multi-cycle WIDTH-bit adder/subtractor: one CHUNK-bit slice per clock behind a
// start/done handshake, with carry, signed-overflow and zero flags.
module multicycle_add #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] OUT,
  output logic             Cout,
  output logic             V,
  output logic             Z,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_part;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  int unsigned      w_base;
  logic [CHUNK-1:0] w_a_sl;
  logic [CHUNK-1:0] w_b_sl;
  logic [CHUNK:0]   w_sum;
  logic [WIDTH-1:0] w_full;
  logic             w_c_msb;
  logic             w_last;

  always_comb begin
    w_base  = 32'(r_cnt) * CHUNK;
    w_a_sl  = r_a[w_base +: CHUNK];
    w_b_sl  = r_b[w_base +: CHUNK];
    w_sum   = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{CHUNK{1'b0}}, r_carry};
    w_full  = r_part;
    w_full[w_base +: CHUNK] = w_sum[CHUNK-1:0];
    // Carry into the slice MSB recovered from the sum bit; only used on the last slice.
    w_c_msb = w_a_sl[CHUNK-1] ^ w_b_sl[CHUNK-1] ^ w_sum[CHUNK-1];
    w_last  = (r_cnt == CW'(NCHUNK - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_part  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      OUT     <= '0;
      Cout    <= 1'b0;
      V       <= 1'b0;
      Z       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= sub ? ~B : B;
            r_carry <= sub ? ~Cin : Cin;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_part  <= w_full;
          r_carry <= w_sum[CHUNK];
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            OUT     <= w_full;
            Cout    <= w_sum[CHUNK];
            V       <= w_c_msb ^ w_sum[CHUNK];
            Z       <= ~|w_full;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_add.sv
// Bench for multicycle_add: directed table on the default configuration, handshake
// corner cases, and random operands on four WIDTH/CHUNK configurations.
module tb_multicycle_add;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]       st, sb, ci, co, vo, zo, bz, dn;
  logic [3:0][31:0] ia, ib, o;
  logic [15:0]      o0, o1, o2;
  logic [31:0]      o3;

  assign o[0] = {16'h0, o0};
  assign o[1] = {16'h0, o1};
  assign o[2] = {16'h0, o2};
  assign o[3] = o3;

  multicycle_add #(.WIDTH(16), .CHUNK(4)) u_d0 (
    .clk(clk), .rst(rst), .start(st[0]), .sub(sb[0]), .A(ia[0][15:0]), .B(ib[0][15:0]),
    .Cin(ci[0]), .OUT(o0), .Cout(co[0]), .V(vo[0]), .Z(zo[0]), .busy(bz[0]), .done(dn[0]));
  multicycle_add #(.WIDTH(16), .CHUNK(1)) u_d1 (
    .clk(clk), .rst(rst), .start(st[1]), .sub(sb[1]), .A(ia[1][15:0]), .B(ib[1][15:0]),
    .Cin(ci[1]), .OUT(o1), .Cout(co[1]), .V(vo[1]), .Z(zo[1]), .busy(bz[1]), .done(dn[1]));
  multicycle_add #(.WIDTH(16), .CHUNK(16)) u_d2 (
    .clk(clk), .rst(rst), .start(st[2]), .sub(sb[2]), .A(ia[2][15:0]), .B(ib[2][15:0]),
    .Cin(ci[2]), .OUT(o2), .Cout(co[2]), .V(vo[2]), .Z(zo[2]), .busy(bz[2]), .done(dn[2]));
  multicycle_add #(.WIDTH(32), .CHUNK(8)) u_d3 (
    .clk(clk), .rst(rst), .start(st[3]), .sub(sb[3]), .A(ia[3]), .B(ib[3]),
    .Cin(ci[3]), .OUT(o3), .Cout(co[3]), .V(vo[3]), .Z(zo[3]), .busy(bz[3]), .done(dn[3]));

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        s;
    logic [15:0] a, b;
    logic        c;
    logic [15:0] out;
    logic        cout, v, z;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Arithmetic reference: plain integer add, flags from operand/result signs.
  function automatic void model(input int w, input logic s, input logic [31:0] a,
                                input logic [31:0] b, input logic c,
                                output logic [31:0] out, output logic cout,
                                output logic v, output logic z);
    logic [63:0] mask, aa, bb, sum;
    logic        sa, sbv, sr;
    mask = (64'd1 << w) - 64'd1;
    aa   = {32'h0, a} & mask;
    bb   = s ? (~{32'h0, b} & mask) : ({32'h0, b} & mask);
    sum  = aa + bb + {63'h0, (s ? ~c : c)};
    out  = 32'(sum & mask);
    cout = sum[w];
    sa   = aa[w-1];
    sbv  = bb[w-1];
    sr   = sum[w-1];
    v    = (sa == sbv) && (sr != sa);
    z    = ((sum & mask) == 64'h0);
  endfunction

  task automatic run_op(input int inst, input int nch, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic c, output int lat);
    sb[inst] = s; ia[inst] = a; ib[inst] = b; ci[inst] = c; st[inst] = 1'b1;
    step();
    st[inst] = 1'b0;
    ia[inst] = $urandom; ib[inst] = $urandom; sb[inst] = 1'($urandom); ci[inst] = 1'($urandom);
    chk("busy_after_accept", 32'(bz[inst]), 32'd1);
    lat = 0;
    for (int n = 1; n <= nch + 4; n++) begin
      step();
      if (dn[inst]) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[8];
    int          lat, nd, ln;
    logic [31:0] cap, e_out, ra, rb;
    logic        e_c, e_v, e_z, rs, rc;
    int          widths[4];
    int          nchs[4];

    tbl[0] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 16'h0010, 16'h0001, 1'b1, 16'h000E, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    widths = '{16, 16, 16, 32};
    nchs   = '{4, 16, 1, 4};

    rst = 1'b1; st = '0; sb = '0; ci = '0; ia = '0; ib = '0;
    repeat (2) step();
    chk("rst_out",  o[0], 32'h0);
    chk("rst_cout", 32'(co[0]), 32'd0);
    chk("rst_v",    32'(vo[0]), 32'd0);
    chk("rst_z",    32'(zo[0]), 32'd0);
    chk("rst_busy", 32'(bz), 32'd0);
    chk("rst_done", 32'(dn), 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      run_op(0, 4, tbl[i].s, {16'h0, tbl[i].a}, {16'h0, tbl[i].b}, tbl[i].c, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      chk($sformatf("vec%0d_out", i),  o[0], {16'h0, tbl[i].out});
      chk($sformatf("vec%0d_cout", i), 32'(co[0]), 32'(tbl[i].cout));
      chk($sformatf("vec%0d_v", i),    32'(vo[0]), 32'(tbl[i].v));
      chk($sformatf("vec%0d_z", i),    32'(zo[0]), 32'(tbl[i].z));
    end
    step();
    chk("done_one_cycle", 32'(dn[0]), 32'd0);
    chk("out_hold", o[0], 32'h0);
    chk("z_hold", 32'(zo[0]), 32'd1);

    // start re-pulsed with different operands while busy must be ignored.
    sb[0] = 1'b0; ia[0] = 32'h1111; ib[0] = 32'h2222; ci[0] = 1'b0; st[0] = 1'b1;
    step();
    ia[0] = 32'hFFFF; ib[0] = 32'hFFFF; sb[0] = 1'b1; ci[0] = 1'b1;
    nd = 0; ln = 0; cap = '0;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (n == 2) st[0] = 1'b0;
      if (dn[0]) begin
        nd++;
        ln = n;
        cap = o[0];
      end
    end
    chk("ignore_done_count", 32'(nd), 32'd1);
    chk("ignore_latency", 32'(ln), 32'd4);
    chk("ignore_out", cap, 32'h3333);

    // Asynchronous reset in the middle of RUN, then start held high across release.
    sb[0] = 1'b0; ia[0] = 32'h0100; ib[0] = 32'h0200; ci[0] = 1'b0; st[0] = 1'b1;
    step();
    st[0] = 1'b0;
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out", o[0], 32'h0);
    chk("midrst_busy", 32'(bz[0]), 32'd0);
    chk("midrst_done", 32'(dn[0]), 32'd0);
    sb[0] = 1'b0; ia[0] = 32'h0F0F; ib[0] = 32'h00F1; ci[0] = 1'b0; st[0] = 1'b1;
    step();
    chk("rst_held_no_accept", 32'(bz[0]), 32'd0);
    nd = 0;
    if (dn[0]) nd++;
    rst = 1'b0;
    step();
    st[0] = 1'b0;
    chk("release_accept_busy", 32'(bz[0]), 32'd1);
    ln = 0;
    for (int n = 1; n <= 8; n++) begin
      step();
      if (dn[0]) begin
        nd++;
        if (ln == 0) begin
          ln = n;
          cap = o[0];
        end
      end
    end
    chk("post_rst_done_count", 32'(nd), 32'd1);
    chk("post_rst_latency", 32'(ln), 32'd4);
    chk("post_rst_out", cap, 32'h1000);

    // Random operands on every configuration; consecutive run_op calls start in the done cycle.
    for (int inst = 0; inst < 4; inst++) begin
      for (int k = 0; k < 25; k++) begin
        ra = $urandom; rb = $urandom; rs = 1'($urandom); rc = 1'($urandom);
        if (widths[inst] == 16) begin
          ra = {16'h0, ra[15:0]};
          rb = {16'h0, rb[15:0]};
        end
        if (k == 0) begin
          ra = (widths[inst] == 16) ? 32'h0000FFFF : 32'hFFFFFFFF;
          rb = 32'h1; rs = 1'b0; rc = 1'b0;
        end
        model(widths[inst], rs, ra, rb, rc, e_out, e_c, e_v, e_z);
        run_op(inst, nchs[inst], rs, ra, rb, rc, lat);
        chk($sformatf("rnd%0d_%0d_latency", inst, k), 32'(lat), 32'(nchs[inst]));
        chk($sformatf("rnd%0d_%0d_out", inst, k),  o[inst], e_out);
        chk($sformatf("rnd%0d_%0d_cout", inst, k), 32'(co[inst]), 32'(e_c));
        chk($sformatf("rnd%0d_%0d_v", inst, k),    32'(vo[inst]), 32'(e_v));
        chk($sformatf("rnd%0d_%0d_z", inst, k),    32'(zo[inst]), 32'(e_z));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
